// File: rtl/ball_ctrl_if.sv
// Signal bundle between the ball game controller and the rest of the game:
// positions and start come in, motion control, scores and FSM state go out.
interface ball_ctrl_if #(
    parameter int BIT_OF_WIDTH = 3,
    parameter int SCORE_W      = 4
);
    // No valid/ready pairing: every input is sampled on each rising clock edge,
    // and every output is a flop that changes only on the rising clock edge.
    logic                    start;
    logic [BIT_OF_WIDTH-1:0] ball_x;
    logic [BIT_OF_WIDTH-1:0] ball_y;
    logic [BIT_OF_WIDTH-1:0] paddle_l_y;
    logic [BIT_OF_WIDTH-1:0] paddle_r_y;
    logic                    en;
    logic [3:0]              vector;
    logic                    endgame;
    logic [SCORE_W-1:0]      score_l;
    logic [SCORE_W-1:0]      score_r;
    logic [2:0]              state_o;

    modport master (
        output start, ball_x, ball_y, paddle_l_y, paddle_r_y,
        input  en, vector, endgame, score_l, score_r, state_o
    );

    modport slave (
        input  start, ball_x, ball_y, paddle_l_y, paddle_r_y,
        output en, vector, endgame, score_l, score_r, state_o
    );
endinterface

// File: rtl/ball_ctrl.sv
// Ball game-flow controller: bounces, misses, scoring, serve/hold/game-over.
// Define BALL_CTRL_SPIN_EN to make paddle hits set dy from the contact cell.
module ball_ctrl #(
    parameter int WIDTH        = 8,
    parameter int BIT_OF_WIDTH = 3,
    parameter int PADDLE_LEN   = 3,
    parameter int SCORE_W      = 4,
    parameter int WIN_SCORE    = 5,
    parameter int HOLD_CYCLES  = 2048,
    parameter int HOLD_W       = 12
) (
    input  logic        clk,
    input  logic        rst,
    ball_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        HOLD  = 3'd3,
        OVER  = 3'd4
    } state_t;

    localparam int CW = BIT_OF_WIDTH + 1;
    localparam logic [1:0]              DIR_POS   = 2'b01;
    localparam logic [1:0]              DIR_NEG   = 2'b11;
    localparam logic [1:0]              DIR_STAY  = 2'b00;
    localparam logic [BIT_OF_WIDTH-1:0] ROW_MAX   = BIT_OF_WIDTH'(WIDTH - 1);
    localparam logic [BIT_OF_WIDTH-1:0] COL_L     = BIT_OF_WIDTH'(1);
    localparam logic [BIT_OF_WIDTH-1:0] COL_R     = BIT_OF_WIDTH'(WIDTH - 2);
    localparam logic [CW-1:0]           LEN_M1    = CW'(PADDLE_LEN - 1);
    localparam logic [SCORE_W-1:0]      SCORE_MAX = '1;
    localparam logic [SCORE_W-1:0]      WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [HOLD_W-1:0]       HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t                  state_q, state_d;
    logic                    en_q, en_d;
    logic [3:0]              vector_q, vector_d;
    logic                    endgame_q, endgame_d;
    logic [SCORE_W-1:0]      score_l_q, score_l_d;
    logic [SCORE_W-1:0]      score_r_q, score_r_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic [BIT_OF_WIDTH-1:0] prev_x_q, prev_x_d;
    logic [BIT_OF_WIDTH-1:0] prev_y_q, prev_y_d;
    logic [1:0]              serve_dir_q, serve_dir_d;

    logic               move, at_left, at_right, in_pad, miss_l, miss_r;
    logic [CW-1:0]      by_ext, pad_top, pad_bot;
    logic [1:0]         dx_new, dy_new;
    logic [SCORE_W-1:0] score_l_inc, score_r_inc;

    always_comb begin
        state_d     = state_q;
        en_d        = en_q;
        vector_d    = vector_q;
        endgame_d   = endgame_q;
        score_l_d   = score_l_q;
        score_r_d   = score_r_q;
        hold_d      = hold_q;
        serve_dir_d = serve_dir_q;
        prev_x_d    = bus.ball_x;
        prev_y_d    = bus.ball_y;

        move     = (bus.ball_x != prev_x_q) || (bus.ball_y != prev_y_q);
        at_left  = (bus.ball_x == COL_L) && (vector_q[3:2] == DIR_NEG);
        at_right = (bus.ball_x == COL_R) && (vector_q[3:2] == DIR_POS);

        // One extra bit so the bottom of a paddle near the last row never wraps.
        by_ext  = {1'b0, bus.ball_y};
        pad_top = at_left ? {1'b0, bus.paddle_l_y} : {1'b0, bus.paddle_r_y};
        pad_bot = pad_top + LEN_M1;
        in_pad  = (by_ext >= pad_top) && (by_ext <= pad_bot);

        dx_new = vector_q[3:2];
        dy_new = vector_q[1:0];
        miss_l = 1'b0;
        miss_r = 1'b0;
        if (at_left || at_right) begin
            if (in_pad) begin
                dx_new = at_left ? DIR_POS : DIR_NEG;
`ifdef BALL_CTRL_SPIN_EN
                if (by_ext == pad_top)      dy_new = DIR_NEG;
                else if (by_ext == pad_bot) dy_new = DIR_POS;
                else                        dy_new = DIR_STAY;
`endif
            end else begin
                miss_l = at_left;
                miss_r = at_right;
            end
        end
        // Wall rule runs last so spin can never aim the ball off the grid.
        if ((bus.ball_y == '0) && (dy_new == DIR_NEG))         dy_new = DIR_POS;
        else if ((bus.ball_y == ROW_MAX) && (dy_new == DIR_POS)) dy_new = DIR_NEG;

        score_l_inc = (score_l_q == SCORE_MAX) ? score_l_q : score_l_q + 1'b1;
        score_r_inc = (score_r_q == SCORE_MAX) ? score_r_q : score_r_q + 1'b1;

        case (state_q)
            IDLE: begin
                en_d     = 1'b0;
                vector_d = {DIR_STAY, DIR_STAY};
                if (bus.start) begin
                    state_d  = SERVE;
                    en_d     = 1'b1;
                    vector_d = {serve_dir_q, DIR_POS};
                end
            end
            SERVE: state_d = PLAY;
            PLAY: begin
                if (move) begin
                    vector_d = {dx_new, dy_new};
                    if (miss_l) begin
                        score_r_d   = score_r_inc;
                        serve_dir_d = DIR_NEG;
                    end
                    if (miss_r) begin
                        score_l_d   = score_l_inc;
                        serve_dir_d = DIR_POS;
                    end
                    if ((miss_l && score_r_inc == WIN) || (miss_r && score_l_inc == WIN)) begin
                        state_d   = OVER;
                        endgame_d = 1'b1;
                        en_d      = 1'b1;
                        vector_d  = {DIR_STAY, DIR_STAY};
                    end else if (miss_l || miss_r) begin
                        state_d = HOLD;
                        en_d    = 1'b0;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (hold_q == '0) begin
                    state_d  = SERVE;
                    en_d     = 1'b1;
                    vector_d = {serve_dir_q, DIR_POS};
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            OVER: begin
                if (bus.start) begin
                    score_l_d   = '0;
                    score_r_d   = '0;
                    serve_dir_d = DIR_POS;
                    endgame_d   = 1'b0;
                    state_d     = SERVE;
                    en_d        = 1'b1;
                    vector_d    = {DIR_POS, DIR_POS};
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            en_q        <= 1'b0;
            vector_q    <= 4'b0000;
            endgame_q   <= 1'b0;
            score_l_q   <= '0;
            score_r_q   <= '0;
            hold_q      <= '0;
            prev_x_q    <= bus.ball_x;
            prev_y_q    <= bus.ball_y;
            serve_dir_q <= DIR_POS;
        end else begin
            state_q     <= state_d;
            en_q        <= en_d;
            vector_q    <= vector_d;
            endgame_q   <= endgame_d;
            score_l_q   <= score_l_d;
            score_r_q   <= score_r_d;
            hold_q      <= hold_d;
            prev_x_q    <= prev_x_d;
            prev_y_q    <= prev_y_d;
            serve_dir_q <= serve_dir_d;
        end
    end

    assign bus.en      = en_q;
    assign bus.vector  = vector_q;
    assign bus.endgame = endgame_q;
    assign bus.score_l = score_l_q;
    assign bus.score_r = score_r_q;
    assign bus.state_o = state_q;
endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl: rallies, bounces, misses, hold timing, game over
// and reset mid-hold; expected snapshots are queued at drive time and popped at check.
module tb_ball_ctrl;
  localparam int W = 17;
`ifdef BALL_CTRL_SPIN_EN
  localparam bit SPIN = 1'b1;
`else
  localparam bit SPIN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [W-1:0] exp_q[$];

  ball_ctrl_if #(.BIT_OF_WIDTH(3), .SCORE_W(4)) bus ();

  ball_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] pk(input logic [2:0] s, input logic e, input logic [3:0] v,
                                      input logic g, input logic [3:0] sl, input logic [3:0] sr);
    return {s, e, v, g, sl, sr};
  endfunction

  task automatic push(input logic [W-1:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag);
    logic [W-1:0] obs;
    logic [W-1:0] e;
    obs = pk(bus.state_o, bus.en, bus.vector, bus.endgame, bus.score_l, bus.score_r);
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<empty queue>", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed{st,en,vec,eg,sl,sr}=%h expected=%h", tag, obs, e);
      end
    end
  endtask

  task automatic move_to(input logic [2:0] x, input logic [2:0] y, input logic [W-1:0] e,
                         input string tag);
    bus.ball_x = x;
    bus.ball_y = y;
    push(e);
    @(negedge clk);
    check(tag);
  endtask

  // Counts cycles spent in HOLD with en low; a start pulse is injected mid-hold.
  task automatic count_hold(input string tag);
    int n = 0;
    int en_bad = 0;
    bus.ball_x = 3'd3;
    bus.ball_y = 3'd4;
    while (bus.state_o === 3'd3 && n < 3000) begin
      if (bus.en !== 1'b0) en_bad++;
      bus.start = (n == 500);
      n++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    assert (n == 2048 && en_bad == 0) else begin
      errors++;
      $error("FAIL %s hold_cycles=%0d en_high=%0d expected 2048/0", tag, n, en_bad);
    end
  endtask

  initial begin
    logic [3:0] v;
    bus.start      = 1'b0;
    bus.ball_x     = 3'd3;
    bus.ball_y     = 3'd4;
    bus.paddle_l_y = 3'd2;
    bus.paddle_r_y = 3'd2;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push(pk(3'd0, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd0));
    @(negedge clk);
    check("reset");

    bus.start = 1'b1;
    push(pk(3'd1, 1'b1, 4'b0101, 1'b0, 4'd0, 4'd0));
    @(negedge clk);
    bus.start = 1'b0;
    check("serve");
    push(pk(3'd2, 1'b1, 4'b0101, 1'b0, 4'd0, 4'd0));
    @(negedge clk);
    check("play");

    move_to(3'd5, 3'd7, pk(3'd2, 1'b1, 4'b0111, 1'b0, 4'd0, 4'd0), "wall_bottom");
    move_to(3'd5, 3'd0, pk(3'd2, 1'b1, 4'b0101, 1'b0, 4'd0, 4'd0), "wall_top");
    bus.paddle_r_y = 3'd6;
    v = SPIN ? 4'b1100 : 4'b1111;
    move_to(3'd6, 3'd7, pk(3'd2, 1'b1, v, 1'b0, 4'd0, 4'd0), "corner");
    bus.paddle_l_y = 3'd3;
    v = SPIN ? 4'b0100 : 4'b0111;
    move_to(3'd1, 3'd4, pk(3'd2, 1'b1, v, 1'b0, 4'd0, 4'd0), "left_mid");
    bus.paddle_r_y = 3'd4;
    v = SPIN ? 4'b1100 : 4'b1111;
    move_to(3'd6, 3'd5, pk(3'd2, 1'b1, v, 1'b0, 4'd0, 4'd0), "right_mid");
    bus.paddle_l_y = 3'd4;
    move_to(3'd1, 3'd4, pk(3'd2, 1'b1, 4'b0111, 1'b0, 4'd0, 4'd0), "left_top");

    push(pk(3'd2, 1'b1, 4'b0111, 1'b0, 4'd0, 4'd0));
    repeat (2) @(negedge clk);
    check("no_move");
    move_to(3'd3, 3'd4, pk(3'd2, 1'b1, 4'b0111, 1'b0, 4'd0, 4'd0), "mid_field");

    bus.paddle_r_y = 3'd5;
    move_to(3'd6, 3'd2, pk(3'd3, 1'b0, 4'b0111, 1'b0, 4'd1, 4'd0), "miss_r");
    count_hold("hold_len_r");
    push(pk(3'd1, 1'b1, 4'b0101, 1'b0, 4'd1, 4'd0));
    check("reserve_r");
    push(pk(3'd2, 1'b1, 4'b0101, 1'b0, 4'd1, 4'd0));
    @(negedge clk);
    check("replay_r");

    bus.paddle_r_y = 3'd2;
    v = SPIN ? 4'b1100 : 4'b1101;
    move_to(3'd6, 3'd3, pk(3'd2, 1'b1, v, 1'b0, 4'd1, 4'd0), "r_return");
    bus.paddle_l_y = 3'd0;
    move_to(3'd1, 3'd6, pk(3'd3, 1'b0, v, 1'b0, 4'd1, 4'd1), "miss_l1");
    for (int k = 2; k <= 5; k++) begin
      count_hold("hold_len_l");
      push(pk(3'd1, 1'b1, 4'b1101, 1'b0, 4'd1, 4'(k - 1)));
      check("reserve_l");
      push(pk(3'd2, 1'b1, 4'b1101, 1'b0, 4'd1, 4'(k - 1)));
      @(negedge clk);
      check("replay_l");
      if (k < 5)
        move_to(3'd1, 3'd6, pk(3'd3, 1'b0, 4'b1101, 1'b0, 4'd1, 4'(k)), "miss_l");
      else
        move_to(3'd1, 3'd6, pk(3'd4, 1'b1, 4'b0000, 1'b1, 4'd1, 4'd5), "game_over");
    end

    move_to(3'd4, 3'd4, pk(3'd4, 1'b1, 4'b0000, 1'b1, 4'd1, 4'd5), "over_hold");
    bus.start = 1'b1;
    push(pk(3'd1, 1'b1, 4'b0101, 1'b0, 4'd0, 4'd0));
    @(negedge clk);
    bus.start = 1'b0;
    check("restart");
    push(pk(3'd2, 1'b1, 4'b0101, 1'b0, 4'd0, 4'd0));
    @(negedge clk);
    check("restart_play");

    bus.paddle_r_y = 3'd5;
    move_to(3'd6, 3'd2, pk(3'd3, 1'b0, 4'b0101, 1'b0, 4'd1, 4'd0), "miss_r2");
    push(pk(3'd3, 1'b0, 4'b0101, 1'b0, 4'd1, 4'd0));
    repeat (1047) @(negedge clk);
    check("hold_mid");
    rst = 1'b1;
    push(pk(3'd0, 1'b0, 4'b0000, 1'b0, 4'd0, 4'd0));
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_hold");
    bus.start = 1'b1;
    push(pk(3'd1, 1'b1, 4'b0101, 1'b0, 4'd0, 4'd0));
    @(negedge clk);
    bus.start = 1'b0;
    check("serve_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
